// File: rtl/matrix_result_drain.sv
// rtl/matrix_result_drain.sv - snapshots a 4x4 16-bit result matrix and streams it out narrowed to 8 bits
// Optional feature macro: MATRIX_DRAIN_ROUND_EN (round-half-up before the right shift)
module matrix_result_drain #(
    parameter int SHIFT = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [3:0][3:0][15:0]  c,
    output logic [7:0]             out_data,
    output logic [1:0]             out_row,
    output logic [1:0]             out_col,
    output logic                   out_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   sat_flag
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

`ifdef MATRIX_DRAIN_ROUND_EN
    // Half of one output LSB; (1<<SHIFT)>>1 is zero when SHIFT is zero.
    localparam logic [16:0] ROUND_ADD = 17'((17'd1 << SHIFT) >> 1);
`endif

    logic [1:0]  state;
    logic [3:0]  idx;
    logic [15:0] snap [0:15];
    logic [15:0] elem;
    logic [16:0] v;
    logic        elem_sat;
    logic        xfer;
    logic        accept;

    assign accept    = (state == IDLE) && start;
    assign xfer      = (state == STREAM) && out_ready;
    assign busy      = (state == STREAM);
    assign out_valid = (state == STREAM);
    assign done      = (state == DONE);
    assign out_row   = idx[3:2];
    assign out_col   = idx[1:0];
    assign out_last  = (state == STREAM) && (idx == 4'hF);

    // Narrow the element at the current index: optional rounding, shift, clamp to 255.
    always_comb begin
        elem = snap[idx];
`ifdef MATRIX_DRAIN_ROUND_EN
        v = ({1'b0, elem} + ROUND_ADD) >> SHIFT;
`else
        v = {1'b0, elem} >> SHIFT;
`endif
        elem_sat = |v[16:8];
        out_data = elem_sat ? 8'hFF : v[7:0];
    end

    // Frame control: IDLE -> STREAM on start, STREAM -> DONE on last transfer, DONE lasts one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state <= STREAM;
                STREAM:  if (xfer && (idx == 4'hF)) state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Row-major element index; holds at (3,3) after the last transfer so it never wraps in a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= 4'd0;
        end else if (accept) begin
            idx <= 4'd0;
        end else if (xfer && (idx != 4'hF)) begin
            idx <= idx + 4'd1;
        end
    end

    // Capture the whole matrix on start so later changes on c cannot disturb the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 16; k++) snap[k] <= 16'd0;
        end else if (accept) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    snap[i*4 + j] <= c[i][j];
                end
            end
        end
    end

    // Sticky saturation indicator for the current frame, cleared only by a new frame or reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_flag <= 1'b0;
        end else if (accept) begin
            sat_flag <= 1'b0;
        end else if (xfer && elem_sat) begin
            sat_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_matrix_result_drain.sv
// tb/tb_matrix_result_drain.sv - scoreboard bench for matrix_result_drain
module tb_matrix_result_drain;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [3:0][3:0][15:0] c;
    logic [7:0]            out_data;
    logic [1:0]            out_row, out_col;
    logic                  out_last, out_valid, out_ready, busy, done, sat_flag;

    logic                  start2;
    logic [3:0][3:0][15:0] c2;
    logic [7:0]            d2_data;
    logic [1:0]            d2_row, d2_col;
    logic                  d2_last, d2_valid, d2_ready, d2_busy, d2_done, d2_sat;

    always #5 clk = ~clk;

    matrix_result_drain #(.SHIFT(0)) u_dut (
        .clk(clk), .rst(rst), .start(start), .c(c),
        .out_data(out_data), .out_row(out_row), .out_col(out_col), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done), .sat_flag(sat_flag)
    );

    matrix_result_drain #(.SHIFT(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .c(c2),
        .out_data(d2_data), .out_row(d2_row), .out_col(d2_col), .out_last(d2_last),
        .out_valid(d2_valid), .out_ready(d2_ready), .busy(d2_busy), .done(d2_done), .sat_flag(d2_sat)
    );

    typedef struct {
        logic [7:0] d;
        logic [1:0] r;
        logic [1:0] cc;
        logic       l;
        logic       s;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic exp_sat  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic logic [16:0] model_v(input logic [15:0] x, input int sh);
        int unsigned t;
        t = x;
`ifdef MATRIX_DRAIN_ROUND_EN
        if (sh > 0) t = t + (1 << (sh - 1));
`endif
        t = t / (1 << sh);
        return 17'(t);
    endfunction

    function automatic logic [7:0] model_d(input logic [15:0] x, input int sh);
        logic [16:0] v;
        v = model_v(x, sh);
        return (v > 17'd255) ? 8'd255 : v[7:0];
    endfunction

    // Monitor: pop the scoreboard on each transfer, check hold-while-stalled and sat_flag.
    logic       stalled = 1'b0;
    exp_t       held;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stalled = 1'b0;
            exp_sat = 1'b0;
        end else begin
            check("sat_flag", sat_flag, exp_sat);
            if (stalled && out_valid) begin
                check("hold_data", out_data, held.d);
                check("hold_row",  out_row,  held.r);
                check("hold_col",  out_col,  held.cc);
                check("hold_last", out_last, held.l);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("data", out_data, e.d);
                    check("row",  out_row,  e.r);
                    check("col",  out_col,  e.cc);
                    check("last", out_last, e.l);
                    if (e.s) exp_sat = 1'b1;
                end
                stalled = 1'b0;
            end else if (out_valid) begin
                stalled = 1'b1;
                held.d = out_data; held.r = out_row; held.cc = out_col; held.l = out_last;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic start_frame();
        exp_t e;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                e.d  = model_d(c[i][j], 0);
                e.r  = 2'(i);
                e.cc = 2'(j);
                e.l  = (i == 3) && (j == 3);
                e.s  = (model_v(c[i][j], 0) > 17'd255);
                sb.push_back(e);
            end
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_sat = 1'b0;
        check("first_valid", out_valid, 1);
        check("first_row",   out_row,   0);
        check("first_col",   out_col,   0);
    endtask

    // mode 0: ready always high; 1: ready 1,0,0,1 repeating; 2: ready high, extra start and c change at element 5
    task automatic drain(input int mode, output int cycles);
        int  n    = 0;
        bit  seen = 0;
        while (!seen && n < 200) begin
            case (mode)
                1:       out_ready = ((n % 4) == 0) || ((n % 4) == 3);
                default: out_ready = 1'b1;
            endcase
            if (mode == 2 && n == 5) begin
                start = 1'b1;
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < 4; j++)
                        c[i][j] = 16'($urandom_range(0, 1000));
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
            if (done) seen = 1;
        end
        start = 1'b0;
        out_ready = 1'b0;
        if (!seen) check("done_timeout", 0, 1);
        cycles = n;
        check("sb_empty_at_done", sb.size(), 0);
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
        check("idle_valid", out_valid, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        int cyc;
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; c = '0;
        start2 = 1'b0; d2_ready = 1'b0; c2 = '0;
        #2;
        check("rst_valid", out_valid, 0);
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_sat",   sat_flag, 0);
        check("rst_data",  out_data, 0);
        check("rst_row",   out_row, 0);
        check("rst_col",   out_col, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Ramp 0..15, continuous ready
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) c[i][j] = 16'(4*i + j);
        start_frame();
        check("busy_in_stream", busy, 1);
        drain(0, cyc);
        check("ramp_cycles", cyc, 16);
        check("ramp_sat", sat_flag, 0);

        // Single saturating element
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) c[i][j] = 16'd10;
        c[1][2] = 16'd300;
        start_frame();
        drain(0, cyc);
        check("sat_cycles", cyc, 16);
        check("sat_after_done", sat_flag, 1);

        // Stalled consumer
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) c[i][j] = 16'($urandom_range(0, 600));
        start_frame();
        drain(1, cyc);
        check("stall_cycles", cyc, 32);

        // Start re-pulsed and c changed mid-frame
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) c[i][j] = 16'(100 + 7*i + j);
        start_frame();
        drain(2, cyc);
        check("restart_cycles", cyc, 16);

        // Reset at element 7
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) c[i][j] = 16'(200 + 4*i + j);
        start_frame();
        out_ready = 1'b1;
        repeat (7) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_busy",  busy, 0);
        check("midrst_data",  out_data, 0);
        check("midrst_row",   out_row, 0);
        sb.delete();
        out_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; check("midrst_no_done", done, 0); end
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_no_done", done, 0);
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) c[i][j] = 16'(4*i + j + 50);
        start_frame();
        drain(0, cyc);
        check("post_rst_cycles", cyc, 16);

        // SHIFT=2 instance: 6 >> 2 is 1 truncated, 2 rounded
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) c2[i][j] = 16'h0006;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        check("s2_valid", d2_valid, 1);
`ifdef MATRIX_DRAIN_ROUND_EN
        check("s2_data", d2_data, 2);
`else
        check("s2_data", d2_data, 1);
`endif
        d2_ready = 1'b1;
        cyc = 0;
        while (!d2_done && cyc < 40) begin @(posedge clk); #1; cyc++; end
        check("s2_cycles", cyc, 16);
        check("s2_sat", d2_sat, 0);
        d2_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_result_drain.md
MATRIX_RESULT_DRAIN -- requirements
Module: matrix_result_drain

Interface
REQ-001 SHALL have parameter SHIFT, default 0, range 0..8: right-shift applied to each 16-bit result before narrowing.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request to snapshot and drain the matrix.
REQ-005 SHALL have port c, input, 4x4 array of 16 bits: unsigned result matrix from the addition stage.
REQ-006 SHALL have port out_data, output, 8 bits: narrowed element.
REQ-007 SHALL have port out_row, output, 2 bits: row index of out_data.
REQ-008 SHALL have port out_col, output, 2 bits: column index of out_data.
REQ-009 SHALL have port out_last, output, 1 bit: high with element (3,3).
REQ-010 SHALL have port out_valid, output, 1 bit: out_data/out_row/out_col/out_last are valid.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts the current element.
REQ-012 SHALL have port busy, output, 1 bit: high in STREAM state.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse after the last transfer.
REQ-014 SHALL have port sat_flag, output, 1 bit: sticky; some element of the current frame saturated.

Function
REQ-015 SHALL implement states IDLE, STREAM and DONE.
REQ-016 In IDLE, start=1 SHALL, on that edge, snapshot all 16 elements of c into internal registers, set index to (0,0), clear sat_flag and enter STREAM.
REQ-017 Changes on c after the snapshot edge SHALL NOT affect the frame being drained.
REQ-018 out_valid SHALL be high exactly while in STREAM; the first element SHALL be valid on the cycle after start is accepted (latency 1).
REQ-019 Element value SHALL be v = snap[row][col] >> SHIFT, then out_data = (v > 255) ? 255 : v[7:0].
REQ-020 out_data SHALL be computed combinationally from the snapshot and the current index; no extra pipeline stage.
REQ-021 A transfer SHALL occur on an edge where out_valid && out_ready.
REQ-022 Index order SHALL be row-major: (0,0),(0,1)..(0,3),(1,0)..(3,3).
REQ-023 On each transfer the index SHALL advance by one.
REQ-024 With out_ready low, out_data, out_row, out_col and out_last SHALL hold stable.
REQ-025 On a transfer of a saturated element, sat_flag SHALL be set; it SHALL hold until the next accepted start or reset.
REQ-026 A transfer with out_last=1 SHALL move the block to DONE; in DONE, done=1 for exactly one cycle, then the block returns to IDLE.
REQ-027 start SHALL be ignored in STREAM and DONE; it SHALL NOT restart or corrupt the frame.
REQ-028 Continuous out_ready=1 SHALL drain the frame in 16 consecutive cycles; from start accept to done is 17 edges.
REQ-029 Index counters SHALL be 4 bits total with no wrap beyond (3,3) inside a frame.

Reset
REQ-030 rst=1 SHALL asynchronously force: state IDLE, out_valid 0, busy 0, done 0, sat_flag 0, index (0,0), snapshot all zero, so out_data reads 0.
REQ-031 Reset mid-frame SHALL abandon the frame with no done pulse; the first start after rst deasserts SHALL begin a fresh frame.

Configuration
REQ-032 Macro MATRIX_DRAIN_ROUND_EN, when defined, SHALL apply round-half-up before the shift: v = (snap + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >> SHIFT, computed in 17 bits to avoid overflow.
REQ-033 Without MATRIX_DRAIN_ROUND_EN, the shift SHALL truncate as in REQ-019; the interface SHALL be identical either way.

Verification
REQ-034 SHIFT=0, c[i][j]=4i+j, out_ready=1, pulse start: 16 elements 0..15 on consecutive cycles; out_last only on (3,3); done on the following cycle; sat_flag=0.
REQ-035 SHIFT=0, c[1][2]=300, others 10: element (1,2) reads 255; sat_flag rises after that transfer and stays 1 after done.
REQ-036 out_ready toggled 1,0,0,1 repeating: every element appears once, in order, stable while stalled; done only after the 16th transfer.
REQ-037 start pulsed again at element 5 and c changed mid-frame: output sequence unchanged; no restart.
REQ-038 rst asserted at element 7: out_valid drops immediately, no done; a new start drains from (0,0).
REQ-039 SHIFT=2, c=0x0006: truncation gives out_data 1; with MATRIX_DRAIN_ROUND_EN, out_data is 2.
